// File: rtl/cpu_bus_pkg.sv
// -----------------------------------------------------------------------------
// cpu_bus_pkg
// Shared definitions for the CPU write-capture path: CPU bus widths, the
// captured write entry, the cartridge ROM window, and the address-decode helper.
// -----------------------------------------------------------------------------
package cpu_bus_pkg;

  localparam int CPU_ADDR_W = 15;
  localparam int CPU_DATA_W = 8;

  // The full 16-bit range selected by /ROMSEL. cpu_addr_in carries only A14..A0.
  localparam logic [15:0] ROM_WINDOW_BASE = 16'h8000;
  localparam logic [15:0] ROM_WINDOW_LAST = 16'hFFFF;

  typedef struct packed {
    logic [CPU_ADDR_W-1:0] addr;
    logic [CPU_DATA_W-1:0] data;
  } wr_entry_t;

  // A mask bit of 0 marks that address bit as don't-care.
  function automatic logic addr_match(input logic [CPU_ADDR_W-1:0] addr,
                                      input logic [CPU_ADDR_W-1:0] mask,
                                      input logic [CPU_ADDR_W-1:0] match);
    return (addr & mask) == match;
  endfunction

endpackage

// File: rtl/write_fifo2.sv
// -----------------------------------------------------------------------------
// write_fifo2
// Two-entry FIFO (head register plus one entry behind it). The head is the
// registered output, so a push becomes visible one cycle after its edge.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, push_entry write request and its entry
//   pop              consumer takes the head (caller qualifies it with !empty)
//   head_entry       current head entry
//   empty            no valid entry
//   drop             push refused because both entries are full and no pop
// -----------------------------------------------------------------------------
module write_fifo2
  import cpu_bus_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wr_entry_t push_entry,
  input  logic      pop,
  output wr_entry_t head_entry,
  output logic      empty,
  output logic      drop
);

  wr_entry_t head_q, head_d;
  wr_entry_t tail_q, tail_d;
  logic      head_valid_q, head_valid_d;
  logic      tail_valid_q, tail_valid_d;

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    head_valid_d = head_valid_q;
    tail_valid_d = tail_valid_q;
    drop         = 1'b0;
    unique case ({push, pop})
      2'b11: begin
        // Head leaves while a new entry arrives: count stays the same.
        if (tail_valid_q) begin
          head_d = tail_q;
          tail_d = push_entry;
        end else begin
          head_d = push_entry;
        end
      end
      2'b01: begin
        // Keep the old head contents when nothing moves up behind it.
        if (tail_valid_q) head_d = tail_q;
        head_valid_d = tail_valid_q;
        tail_valid_d = 1'b0;
      end
      2'b10: begin
        if (!head_valid_q) begin
          head_d       = push_entry;
          head_valid_d = 1'b1;
        end else if (!tail_valid_q) begin
          tail_d       = push_entry;
          tail_valid_d = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      head_valid_q <= 1'b0;
      tail_valid_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      head_valid_q <= head_valid_d;
      tail_valid_q <= tail_valid_d;
    end
  end

  assign head_entry = head_q;
  assign empty      = !head_valid_q;

endmodule

// File: rtl/cpu_write_capture.sv
// -----------------------------------------------------------------------------
// cpu_write_capture
// Captures CPU writes to the cartridge ROM window on the M2 clock, applies the
// address decode, optional bus-conflict AND and the read-modify-write double
// write filter, and queues accepted writes for the bank-register stage.
// Ports:
//   m2, rst_n                      clock, asynchronous active-low reset
//   romsel, cpu_rw_in              /ROMSEL and R/W (write when both low)
//   cpu_addr_in, cpu_data_in       A14..A0 and data bus
//   rom_data_in                    flash output, ANDed in when BUS_CONFLICT=1
//   out_valid/out_ready/out_addr/out_data   head of the write queue
//   overflow, overflow_clr         sticky dropped-write flag and its clear
//   led                            active-low activity indicator (stretched)
// -----------------------------------------------------------------------------
module cpu_write_capture
  import cpu_bus_pkg::*;
#(
  parameter logic [CPU_ADDR_W-1:0] ADDR_MASK          = 15'h0000,
  parameter logic [CPU_ADDR_W-1:0] ADDR_MATCH         = 15'h0000,
  parameter int                    BUS_CONFLICT       = 0,
  parameter int                    IGNORE_CONSECUTIVE = 1,
  parameter logic [15:0]           LED_CYCLES         = 16'd50000
) (
  input  logic                  m2,
  input  logic                  rst_n,
  input  logic                  romsel,
  input  logic                  cpu_rw_in,
  input  logic [CPU_ADDR_W-1:0] cpu_addr_in,
  input  logic [CPU_DATA_W-1:0] cpu_data_in,
  input  logic [CPU_DATA_W-1:0] rom_data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CPU_ADDR_W-1:0] out_addr,
  output logic [CPU_DATA_W-1:0] out_data,
  output logic                  overflow,
  input  logic                  overflow_clr,
  output logic                  led
);

  logic        window_hit;
  logic        accept;
  logic        pop;
  logic        fifo_empty;
  logic        fifo_drop;
  wr_entry_t   new_entry;
  wr_entry_t   head_entry;

  logic        prev_hit_q, prev_hit_d;
  logic        overflow_q, overflow_d;
  logic        led_q, led_d;
  logic [15:0] led_cnt_q, led_cnt_d;

  always_comb begin
    window_hit = !romsel && !cpu_rw_in &&
                 addr_match(cpu_addr_in, ADDR_MASK, ADDR_MATCH);
    // A read-modify-write instruction writes twice on consecutive cycles;
    // only the first write of a back-to-back run is kept.
    accept     = window_hit && !((IGNORE_CONSECUTIVE != 0) && prev_hit_q);
    // prev_hit follows raw hits, including filtered ones, so a long run
    // keeps suppressing until a gap cycle appears.
    prev_hit_d = window_hit;

    new_entry.addr = cpu_addr_in;
    new_entry.data = (BUS_CONFLICT != 0) ? (cpu_data_in & rom_data_in) : cpu_data_in;

    // A drop in the clear cycle still leaves the flag set.
    if (fifo_drop)         overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
    else                   overflow_d = overflow_q;

    led_cnt_d = led_cnt_q;
    led_d     = led_q;
    if (accept) begin
      led_cnt_d = LED_CYCLES;
      led_d     = 1'b0;
    end else if (led_cnt_q != 16'd0) begin
      led_cnt_d = led_cnt_q - 16'd1;
      led_d     = (led_cnt_d == 16'd0);
    end else begin
      led_d     = 1'b1;
    end
  end

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  write_fifo2 u_fifo (
    .clk        (m2),
    .rst_n      (rst_n),
    .push       (accept),
    .push_entry (new_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .empty      (fifo_empty),
    .drop       (fifo_drop)
  );

  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      prev_hit_q <= 1'b0;
      overflow_q <= 1'b0;
      led_q      <= 1'b1;
      led_cnt_q  <= 16'd0;
    end else begin
      prev_hit_q <= prev_hit_d;
      overflow_q <= overflow_d;
      led_q      <= led_d;
      led_cnt_q  <= led_cnt_d;
    end
  end

  assign out_addr = head_entry.addr;
  assign out_data = head_entry.data;
  assign overflow = overflow_q;
  assign led      = led_q;

endmodule

// File: tb/tb_cpu_write_capture.sv
// -----------------------------------------------------------------------------
// tb_cpu_write_capture
// Two instances share the CPU bus: dut_a uses the default decode with the
// double-write filter on; dut_b decodes ADDR_MASK=6000/ADDR_MATCH=2000 with the
// bus-conflict AND and no filter. Each has its own /ROMSEL so writes can be
// aimed at one or both. Expected entries go into per-instance queues; the
// monitor pops them whenever an instance hands over an entry.
// -----------------------------------------------------------------------------
module tb_cpu_write_capture;

  typedef struct packed {
    logic [14:0] addr;
    logic [7:0]  data;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] req;
  } pt_t;

  logic        m2 = 1'b0;
  logic        rst_n = 1'b0;
  logic        romsel_a = 1'b1;
  logic        romsel_b = 1'b1;
  logic        cpu_rw = 1'b1;
  logic [14:0] addr = '0;
  logic [7:0]  data = '0;
  logic [7:0]  rom = 8'hFF;
  logic        out_ready = 1'b0;
  logic        ovf_clr = 1'b0;

  logic        a_valid, a_ovf, a_led;
  logic [14:0] a_addr;
  logic [7:0]  a_data;
  logic        b_valid, b_ovf, b_led;
  logic [14:0] b_addr;
  logic [7:0]  b_data;

  exp_t exp_a[$];
  exp_t exp_b[$];
  pt_t  pt_q[$];
  pt_t  mon_p;
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;

  cpu_write_capture #(
    .LED_CYCLES (16'd3)
  ) dut_a (
    .m2 (m2), .rst_n (rst_n), .romsel (romsel_a), .cpu_rw_in (cpu_rw),
    .cpu_addr_in (addr), .cpu_data_in (data), .rom_data_in (rom),
    .out_valid (a_valid), .out_ready (out_ready), .out_addr (a_addr),
    .out_data (a_data), .overflow (a_ovf), .overflow_clr (ovf_clr), .led (a_led)
  );

  cpu_write_capture #(
    .ADDR_MASK (15'h6000), .ADDR_MATCH (15'h2000), .BUS_CONFLICT (1),
    .IGNORE_CONSECUTIVE (0), .LED_CYCLES (16'd3)
  ) dut_b (
    .m2 (m2), .rst_n (rst_n), .romsel (romsel_b), .cpu_rw_in (cpu_rw),
    .cpu_addr_in (addr), .cpu_data_in (data), .rom_data_in (rom),
    .out_valid (b_valid), .out_ready (out_ready), .out_addr (b_addr),
    .out_data (b_data), .overflow (b_ovf), .overflow_clr (ovf_clr), .led (b_led)
  );

  always #5 m2 = ~m2;

  // Monitor: sole owner of the counters. Point checks recorded by the
  // stimulus are evaluated here, then handed-over entries are scored.
  always @(negedge m2) begin
    while (pt_q.size() > 0) begin
      mon_p = pt_q.pop_front();
      n_total++;
      if (mon_p.act === mon_p.req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", mon_p.name, mon_p.act, mon_p.req);
    end
    if (rst_n && a_valid && out_ready) begin
      n_total++;
      if (exp_a.size() == 0) begin
        $display("FAIL sb_a: got unexpected addr=%h data=%h, required none", a_addr, a_data);
      end else begin
        mon_e = exp_a.pop_front();
        if ({a_addr, a_data} === mon_e) begin
          n_pass++;
          $display("dut_a pop addr=%h data=%h ok", a_addr, a_data);
        end else begin
          $display("FAIL sb_a: got addr=%h data=%h, required addr=%h data=%h",
                   a_addr, a_data, mon_e.addr, mon_e.data);
        end
      end
    end
    if (rst_n && b_valid && out_ready) begin
      n_total++;
      if (exp_b.size() == 0) begin
        $display("FAIL sb_b: got unexpected addr=%h data=%h, required none", b_addr, b_data);
      end else begin
        mon_e = exp_b.pop_front();
        if ({b_addr, b_data} === mon_e) begin
          n_pass++;
          $display("dut_b pop addr=%h data=%h ok", b_addr, b_data);
        end else begin
          $display("FAIL sb_b: got addr=%h data=%h, required addr=%h data=%h",
                   b_addr, b_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge m2);
    #1;
  endtask

  task automatic pt(input string nm, input logic [31:0] act, input logic [31:0] req);
    pt_t p;
    p.name = nm;
    p.act  = act;
    p.req  = req;
    pt_q.push_back(p);
  endtask

  task automatic push_a(input logic [14:0] ad, input logic [7:0] d);
    exp_a.push_back({ad, d});
  endtask

  task automatic push_b(input logic [14:0] ad, input logic [7:0] d);
    exp_b.push_back({ad, d});
  endtask

  task automatic idle();
    romsel_a = 1'b1;
    romsel_b = 1'b1;
    cpu_rw   = 1'b1;
  endtask

  // One write cycle aimed at the selected instances; returns just after its edge.
  task automatic wr(input bit to_a, input bit to_b, input logic [14:0] ad,
                    input logic [7:0] d, input logic [7:0] r);
    romsel_a = !to_a;
    romsel_b = !to_b;
    cpu_rw   = 1'b0;
    addr     = ad;
    data     = d;
    rom      = r;
    tick();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #23;
    pt("rst_a_valid", a_valid, 0);
    pt("rst_a_addr", a_addr, 0);
    pt("rst_a_data", a_data, 0);
    pt("rst_a_ovf", a_ovf, 0);
    pt("rst_a_led", a_led, 1);
    pt("rst_b_valid", b_valid, 0);
    pt("rst_b_led", b_led, 1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // Single write, one-cycle handover, LED low for exactly 3 cycles.
    push_a(15'h0000, 8'h03);
    wr(1, 0, 15'h0000, 8'h03, 8'hFF);
    pt("t1_valid", a_valid, 1);
    pt("t1_data", a_data, 8'h03);
    pt("t1_led0", a_led, 0);
    tick();
    pt("t1_valid_gone", a_valid, 0);
    pt("t1_led1", a_led, 0);
    tick();
    pt("t1_led2", a_led, 0);
    tick();
    pt("t1_led3_off", a_led, 1);
    tick();

    // Back-to-back writes: a keeps only the first; b (no filter) keeps all.
    push_a(15'h2000, 8'h05);
    push_a(15'h2000, 8'h07);
    push_b(15'h2000, 8'h05);
    push_b(15'h2000, 8'h06);
    push_b(15'h2000, 8'h07);
    wr(1, 1, 15'h2000, 8'h05, 8'hFF);
    wr(1, 1, 15'h2000, 8'h06, 8'hFF);
    tick();
    wr(1, 1, 15'h2000, 8'h07, 8'hFF);
    repeat (3) tick();

    // Bus conflict on b: FF AND 02.
    push_b(15'h2001, 8'h02);
    wr(0, 1, 15'h2001, 8'hFF, 8'h02);
    pt("t3_b_data", b_data, 8'h02);
    tick();

    // Decode window on b: 4000 and 6000 miss, 3FFF hits.
    wr(0, 1, 15'h4000, 8'hAA, 8'hFF);
    pt("t4_b_miss_4000", b_valid, 0);
    tick();
    wr(0, 1, 15'h6000, 8'hBB, 8'hFF);
    pt("t4_b_miss_6000", b_valid, 0);
    tick();
    push_b(15'h3FFF, 8'h5A);
    wr(0, 1, 15'h3FFF, 8'h5A, 8'hFF);
    pt("t4_b_hit_3fff", b_valid, 1);
    repeat (2) tick();

    // Overflow: three writes into a stalled buffer.
    out_ready = 1'b0;
    push_a(15'h0100, 8'h01);
    push_a(15'h0101, 8'h02);
    wr(1, 0, 15'h0100, 8'h01, 8'hFF);
    tick();
    wr(1, 0, 15'h0101, 8'h02, 8'hFF);
    pt("t5_no_ovf_yet", a_ovf, 0);
    tick();
    wr(1, 0, 15'h0102, 8'h03, 8'hFF);
    pt("t5_ovf_set", a_ovf, 1);
    pt("t5_head_held", a_data, 8'h01);
    tick();
    pt("t5_ovf_sticky", a_ovf, 1);
    out_ready = 1'b1;
    repeat (3) tick();
    pt("t5_drained", a_valid, 0);
    pt("t5_ovf_still", a_ovf, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    pt("t5_ovf_clr", a_ovf, 0);
    tick();

    // Full buffer, then push and pop in the same cycle.
    out_ready = 1'b0;
    push_a(15'h0200, 8'h11);
    push_a(15'h0201, 8'h12);
    push_a(15'h0202, 8'h13);
    wr(1, 0, 15'h0200, 8'h11, 8'hFF);
    tick();
    wr(1, 0, 15'h0201, 8'h12, 8'hFF);
    tick();
    pt("t6_full_valid", a_valid, 1);
    out_ready = 1'b1;
    wr(1, 0, 15'h0202, 8'h13, 8'hFF);
    pt("t6_no_ovf", a_ovf, 0);
    pt("t6_head_next", a_data, 8'h12);
    repeat (4) tick();
    pt("t6_drained", a_valid, 0);

    // Asynchronous reset with two entries queued and the LED on.
    out_ready = 1'b0;
    wr(1, 0, 15'h0300, 8'h21, 8'hFF);
    tick();
    wr(1, 0, 15'h0301, 8'h22, 8'hFF);
    pt("t7_pre_valid", a_valid, 1);
    pt("t7_pre_led", a_led, 0);
    #2;
    rst_n = 1'b0;
    #1;
    pt("t7_rst_valid", a_valid, 0);
    pt("t7_rst_led", a_led, 1);
    pt("t7_rst_data", a_data, 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    pt("t7_post_valid", a_valid, 0);
    out_ready = 1'b1;
    repeat (3) tick();

    pt("sb_a_left", exp_a.size(), 0);
    pt("sb_b_left", exp_b.size(), 0);
    @(negedge m2);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cpu_write_capture.md
Name: cpu_write_capture

Overview:
- Upstream stage for the mapper bank registers. Detects CPU writes to the cartridge ROM window ($8000-$FFFF, romsel low) on the m2 clock.
- Applies the address decode window, the bus-conflict model and the read-modify-write double-write filter.
- Queues accepted writes in a 2-entry buffer with a valid/ready handshake to the bank-register stage.
- Drives an activity LED with a pulse stretcher.

Parameters:
ADDR_MASK, 15'h0000, cpu_addr_in bits that take part in the decode (0 = don't care).
ADDR_MATCH, 15'h0000, required value of the masked address bits.
BUS_CONFLICT, 0, 1 = captured data is cpu_data_in AND rom_data_in.
IGNORE_CONSECUTIVE, 1, 1 = drop a write that immediately follows an accepted-window write in the previous cycle.
LED_CYCLES, 16'd50000, number of m2 cycles the LED stays on after an accepted write (minimum 1).

Ports:
m2  input  1  clock, CPU M2; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
romsel  input  1  CPU /ROMSEL, active low; stable at the rising edge of m2.
cpu_rw_in  input  1  CPU R/W, 0 = write.
cpu_addr_in  input  15  CPU A14..A0.
cpu_data_in  input  8  CPU data bus.
rom_data_in  input  8  PRG flash output at the same address; used only when BUS_CONFLICT=1.
out_valid  output  1  head entry of the buffer is valid.
out_ready  input  1  consumer accepts the head entry this cycle.
out_addr  output  15  address of the head entry.
out_data  output  8  data of the head entry.
overflow  output  1  sticky flag: a write was dropped because the buffer was full.
overflow_clr  input  1  clears overflow.
led  output  1  active-low activity indicator.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Buffer empty; out_valid=0, out_addr=0, out_data=0.
  - overflow=0, led=1, LED counter=0, prev_hit=0.
  - Reset in the middle of a transfer discards all queued entries; no partial entry survives.
- Raw write event at a rising edge: romsel==0 && cpu_rw_in==0.
- Window hit: raw event && ((cpu_addr_in & ADDR_MASK) == ADDR_MATCH).
- Consecutive filter:
  - prev_hit register stores the raw window-hit status of the previous cycle.
  - With IGNORE_CONSECUTIVE=1, a hit while prev_hit=1 is discarded. The discarded hit still sets prev_hit, so a run of N back-to-back hits yields only its first write.
  - With IGNORE_CONSECUTIVE=0, every hit is accepted.
- Captured data: cpu_data_in, or (cpu_data_in & rom_data_in) when BUS_CONFLICT=1. Width is 8 bits, no extension.
- Buffer: 2-entry FIFO (head plus one behind), each entry {addr[14:0], data[7:0]}.
  - pop = out_valid && out_ready.
  - push = accepted hit.
  - Latency: a push at edge N gives out_valid=1 and the entry on out_addr/out_data after edge N, i.e. 1 cycle.
  - Outputs are registered; out_addr/out_data hold while out_valid=1 && out_ready=0.
  - Empty + pop: no effect.
  - Full + push without pop: entry dropped and overflow set to 1 at that edge.
  - Full + push + pop in the same cycle: both take effect, no overflow.
  - Empty + push + pop: pop is ignored because out_valid=0; the push lands.
  - Order is strictly FIFO.
- overflow:
  - overflow_clr=1 clears it at the next edge.
  - A drop in the same cycle as overflow_clr wins (set).
- LED:
  - Each accepted hit loads the counter with LED_CYCLES and drives led=0.
  - The counter decrements every cycle while nonzero; led returns to 1 at the edge where the counter reaches 0.
  - A new hit during countdown reloads the counter.
- No combinational path from any input to any output.

Decomposition:
- Package cpu_bus_pkg: entry width constants (CPU_ADDR_W=15, CPU_DATA_W=8), the write-entry struct/type, ROM_WINDOW constants.
- One sub-module, write_fifo2: the 2-entry FIFO with push/pop/full/empty/drop.
- Decode, filter and LED logic stay in the top module.

Test Plan:
- Reset, then one write (romsel=0, rw=0, addr=15'h0000, data=8'h03) with out_ready=1 -> out_valid=1 for exactly 1 cycle after the edge, out_data=8'h03, led=0.
- IGNORE_CONSECUTIVE=1, writes 8'h05 then 8'h06 on back-to-back cycles, then idle, then 8'h07 -> consumer receives 8'h05 and 8'h07 only.
- BUS_CONFLICT=1, cpu_data_in=8'hFF, rom_data_in=8'h02 -> out_data=8'h02.
- out_ready=0, three separated writes 8'h01, 8'h02, 8'h03 -> overflow=1; releasing out_ready delivers 8'h01 then 8'h02; overflow_clr pulse -> overflow=0.
- Full buffer, then a push and a pop in the same cycle -> no overflow, order preserved. ADDR_MASK=15'h6000, ADDR_MATCH=15'h2000, write at 15'h4000 -> ignored.
- rst_n asserted while 2 entries are queued and led=0 -> out_valid=0 and led=1 immediately (asynchronous); LED_CYCLES=3 run shows led low for exactly 3 cycles.
